// File: rtl/text_fetch_pkg.sv
// -----------------------------------------------------------------------------
// text_fetch_pkg
// Shared constants for the text-mode fetch stage: screen geometry derived from
// the visible timing of the sync generator, glyph height, memory address
// widths, 3-bit state encodings and a small row-pointer helper.
// No ports (package).
// -----------------------------------------------------------------------------
package text_fetch_pkg;

  // Visible region of the sync generator (800x600); frame_start/line_start
  // are decoded against these so cell counts line up with the raster.
  localparam int H_VISIBLE = 800;
  localparam int V_VISIBLE = 600;
  localparam int CELL_W    = 8;

  // Text geometry. The last character row is only half shown (600/16 = 37.5).
  localparam int FONT_H  = 16;
  localparam int COLS    = H_VISIBLE / CELL_W;
  localparam int ROWS    = (V_VISIBLE + FONT_H - 1) / FONT_H;
  localparam int SCAN_W  = $clog2(FONT_H);
  localparam int COL_W   = $clog2(COLS + 1);

  // Memory address widths; the font ROM is indexed by {code, scanline}.
  localparam int TEXT_AW = 12;
  localparam int FONT_AW = 8 + SCAN_W;

  // Sized copies of the geometry for comparisons and arithmetic.
  localparam logic [COL_W-1:0]   COL_END   = COL_W'(COLS);
  localparam logic [TEXT_AW-1:0] ROW_STEP  = TEXT_AW'(COLS);
  localparam logic [TEXT_AW-1:0] TEXT_END  = TEXT_AW'(COLS * ROWS);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(FONT_H - 1);

  // 3-bit state encodings.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHAR = 3'd1;
  localparam logic [2:0] S_FONT = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    CHAR = S_CHAR,
    FONT = S_FONT,
    LOAD = S_LOAD,
    HOLD = S_HOLD,
    DONE = S_DONE
  } state_t;

  // Next character-row base; sticks at the end of the text area so extra
  // lines past the last row stay blank instead of wrapping the address.
  function automatic logic [TEXT_AW-1:0] next_row_base(input logic [TEXT_AW-1:0] rb);
    logic [TEXT_AW-1:0] nrb;
    if (rb >= TEXT_END) begin
      nrb = rb;
    end else begin
      nrb = rb + ROW_STEP;
    end
    return nrb;
  endfunction

endpackage

// File: rtl/text_fetch_if.sv
// -----------------------------------------------------------------------------
// text_fetch_if
// Bundles the pixel handshake and the two memory read ports of the fetch stage.
//   pix_data  [7:0]      glyph row byte, MSB = leftmost pixel
//   pix_valid            pix_data holds an unconsumed byte
//   pix_ack              consumer took pix_data this cycle
//   text_addr [TEXT_AW]  text RAM address
//   text_rd              text RAM read enable
//   text_data [7:0]      character code, valid the cycle after text_rd
//   font_addr [FONT_AW]  font ROM address {code, scan}
//   font_rd              font ROM read enable
//   font_data [7:0]      glyph row, valid the cycle after font_rd
// master = fetch stage, slave = memories plus pixel consumer.
// -----------------------------------------------------------------------------
interface text_fetch_if;
  import text_fetch_pkg::*;

  logic [7:0]         pix_data;
  logic               pix_valid;
  logic               pix_ack;
  logic [TEXT_AW-1:0] text_addr;
  logic               text_rd;
  logic [7:0]         text_data;
  logic [FONT_AW-1:0] font_addr;
  logic               font_rd;
  logic [7:0]         font_data;

  modport master (
    output pix_data, pix_valid, text_addr, text_rd, font_addr, font_rd,
    input  pix_ack, text_data, font_data
  );

  modport slave (
    input  pix_data, pix_valid, text_addr, text_rd, font_addr, font_rd,
    output pix_ack, text_data, font_data
  );

endinterface

// File: rtl/text_fetch.sv
// -----------------------------------------------------------------------------
// text_fetch
// Text-mode fetch stage feeding the pixel generator. For each 8-pixel cell it
// reads the character code from text RAM, then that code's glyph row from the
// font ROM, and offers the byte on a valid/ack handshake. Character row and
// scanline are tracked locally from frame_start / line_start.
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   frame_start  one-cycle pulse before visible line 0
//   line_start   one-cycle pulse: prefetch the next visible line
//   bus          text_fetch_if master (pixel handshake + memory ports)
// -----------------------------------------------------------------------------
module text_fetch
  import text_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         line_start,
  text_fetch_if.master bus
);

  state_t             state;
  state_t             state_next;
  logic [COL_W-1:0]   col;
  logic [SCAN_W-1:0]  scan;
  logic [TEXT_AW-1:0] row_base;
  logic               blank;
  logic [7:0]         pix_data;
  logic               pix_valid;
  logic               take;

  // An ack only counts while a byte is actually on offer.
  assign take = bus.pix_ack & pix_valid;

  assign bus.pix_data  = pix_data;
  assign bus.pix_valid = pix_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; either sync pulse restarts the fetch from any state.
  always_comb begin
    state_next = state;
    if (frame_start || line_start) begin
      state_next = CHAR;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        CHAR: begin
          // Past the last text row there is nothing to read: skip the font.
          if (blank) begin
            state_next = LOAD;
          end else begin
            state_next = FONT;
          end
        end
        FONT: state_next = LOAD;
        LOAD: state_next = HOLD;
        HOLD: begin
          if (take) begin
            if (col < COL_END) begin
              state_next = CHAR;
            end else begin
              state_next = DONE;
            end
          end else begin
            state_next = HOLD;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Memory strobes and addresses decoded from the current state.
  always_comb begin
    bus.text_rd   = 1'b0;
    bus.text_addr = {TEXT_AW{1'b0}};
    bus.font_rd   = 1'b0;
    bus.font_addr = {FONT_AW{1'b0}};
    case (state)
      CHAR: begin
        bus.text_addr = row_base + TEXT_AW'(col);
        if (blank) begin
          bus.text_rd = 1'b0;
        end else begin
          bus.text_rd = 1'b1;
        end
      end
      FONT: begin
        // text_data is the code returned for the read issued in CHAR.
        bus.font_rd   = 1'b1;
        bus.font_addr = {bus.text_data, scan};
      end
      default: begin
        bus.text_rd = 1'b0;
        bus.font_rd = 1'b0;
      end
    endcase
  end

  // Position tracking and the output byte register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= {COL_W{1'b0}};
      scan      <= {SCAN_W{1'b0}};
      row_base  <= {TEXT_AW{1'b0}};
      blank     <= 1'b0;
      pix_data  <= 8'h00;
      pix_valid <= 1'b0;
    end else if (frame_start) begin
      col       <= {COL_W{1'b0}};
      scan      <= {SCAN_W{1'b0}};
      row_base  <= {TEXT_AW{1'b0}};
      blank     <= 1'b0;
      pix_valid <= 1'b0;
    end else if (line_start) begin
      col       <= {COL_W{1'b0}};
      pix_valid <= 1'b0;
      if (scan == SCAN_LAST) begin
        scan     <= {SCAN_W{1'b0}};
        row_base <= next_row_base(row_base);
        blank    <= (next_row_base(row_base) >= TEXT_END);
      end else begin
        scan <= scan + 1'b1;
      end
    end else begin
      case (state)
        LOAD: begin
          // font_data answers the FONT-state read; blank rows emit background.
          if (blank) begin
            pix_data <= 8'h00;
          end else begin
            pix_data <= bus.font_data;
          end
          pix_valid <= 1'b1;
          col       <= col + 1'b1;
        end
        HOLD: begin
          if (take) begin
            pix_valid <= 1'b0;
          end else begin
            pix_valid <= pix_valid;
          end
        end
        default: begin
          pix_valid <= pix_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_fetch.sv
// -----------------------------------------------------------------------------
// tb_text_fetch
// Directed self-checking bench for text_fetch. Behavioural text RAM and font
// ROM with one-cycle read latency; contents come from small closed-form
// functions so every expected byte is derived from those same functions.
// -----------------------------------------------------------------------------
module tb_text_fetch;
  import text_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic line_start;

  text_fetch_if bus();

  text_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  text_mem [0:4095];
  logic [7:0]  font_mem [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;
  int          text_reads;
  int          font_reads;
  logic [11:0] last_text_addr;

  // Row 0 is all 'A'; other cells carry an address-derived code.
  function automatic logic [7:0] text_f(input logic [11:0] a);
    if (a < 12'd100) return 8'h41;
    else return a[7:0] ^ 8'h5A;
  endfunction

  // Glyph row for (code, scan); ('A', 0) gives 0x18.
  function automatic logic [7:0] font_f(input logic [7:0] code, input logic [3:0] sc);
    return code ^ {sc, sc} ^ 8'h59;
  endfunction

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.text_rd) bus.text_data <= text_mem[bus.text_addr];
    if (bus.font_rd) bus.font_data <= font_mem[bus.font_addr];
  end

  // Read bookkeeping.
  always @(posedge clk) begin
    if (rst) begin
      text_reads <= 0;
      font_reads <= 0;
    end else begin
      if (bus.text_rd) begin
        text_reads     <= text_reads + 1;
        last_text_addr <= bus.text_addr;
      end
      if (bus.font_rd) font_reads <= font_reads + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Steps until pix_valid, bounded; returns the number of edges taken.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.pix_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int reads_snap;
    logic [3:0]  sc;
    logic [11:0] rb;

    for (int a = 0; a < 4096; a++) begin
      text_mem[a] = text_f(12'(a));
      font_mem[a] = font_f(8'(a >> 4), 4'(a));
    end

    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; bus.pix_ack = 1'b0;
    step(2);
    chk("rst_valid", 32'(bus.pix_valid), 32'h0);
    chk("rst_data",  32'(bus.pix_data),  32'h00);
    chk("rst_text_rd", 32'(bus.text_rd), 32'h0);
    chk("rst_font_rd", 32'(bus.font_rd), 32'h0);

    // First fetch after frame_start.
    rst = 1'b0; frame_start = 1'b1;
    step(); frame_start = 1'b0;
    chk("fs_text_rd",   32'(bus.text_rd),   32'h1);
    chk("fs_text_addr", 32'(bus.text_addr), 32'h0);
    step();
    chk("fs_font_rd",   32'(bus.font_rd),   32'h1);
    chk("fs_font_addr", 32'(bus.font_addr), 32'h410);
    step();
    chk("fs_valid_early", 32'(bus.pix_valid), 32'h0);
    step();
    chk("fs_valid", 32'(bus.pix_valid), 32'h1);

    // A full line of 100 cells, consumer acking every 8 cycles.
    for (int k = 0; k < 100; k++) begin
      chk("line_data", 32'(bus.pix_data), 32'h18);
      chk("line_addr", 32'(last_text_addr), 32'(k));
      step(4);
      bus.pix_ack = 1'b1; step(); bus.pix_ack = 1'b0;
      if (k < 99) begin
        wait_valid(lat);
        chk("line_latency", 32'(lat), 32'd3);
      end
    end
    step(10);
    bus.pix_ack = 1'b1; step(); bus.pix_ack = 1'b0;
    step(5);
    chk("done_text_reads", 32'(text_reads), 32'd100);
    chk("done_font_reads", 32'(font_reads), 32'd100);
    chk("done_valid", 32'(bus.pix_valid), 32'h0);
    chk("done_data",  32'(bus.pix_data),  32'h18);

    // 16 line_starts: scan walks 1..15 then wraps to 0 on row 1.
    for (int i = 1; i <= 16; i++) begin
      sc = 4'(i);
      rb = (i == 16) ? 12'd100 : 12'd0;
      line_start = 1'b1; step(); line_start = 1'b0;
      chk("ls_text_rd",   32'(bus.text_rd),   32'h1);
      chk("ls_text_addr", 32'(bus.text_addr), 32'(rb));
      step();
      chk("ls_font_addr", 32'(bus.font_addr), 32'({text_f(rb), sc}));
      step(2);
      chk("ls_data", 32'(bus.pix_data), 32'(font_f(text_f(rb), sc)));
    end

    // line_start lands while the second cell is in FONT: restart cleanly.
    bus.pix_ack = 1'b1; step(); bus.pix_ack = 1'b0;
    chk("ab_col1_addr", 32'(bus.text_addr), 32'd101);
    step();
    chk("ab_in_font", 32'(bus.font_rd), 32'h1);
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("ab_text_addr", 32'(bus.text_addr), 32'd100);
    chk("ab_valid0",    32'(bus.pix_valid), 32'h0);
    step();
    chk("ab_font_addr", 32'(bus.font_addr), 32'({text_f(12'd100), 4'h1}));
    step();
    chk("ab_no_stale", 32'(bus.pix_valid), 32'h0);
    step();
    chk("ab_data", 32'(bus.pix_data), 32'(font_f(text_f(12'd100), 4'h1)));

    // frame_start wins over a simultaneous line_start.
    frame_start = 1'b1; line_start = 1'b1; step(); frame_start = 1'b0; line_start = 1'b0;
    chk("both_text_addr", 32'(bus.text_addr), 32'h0);
    step();
    chk("both_font_addr", 32'(bus.font_addr), 32'h410);

    // Sweep the frame: lines 1..606.
    for (int ln = 1; ln <= 606; ln++) begin
      line_start = 1'b1; step(); line_start = 1'b0; step();
      if (ln == 320) chk("sweep_row20", 32'(last_text_addr), 32'd2000);
    end
    // Line 607 is row 37, scan 15.
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("last_text_addr", 32'(bus.text_addr), 32'd3700);
    chk("last_text_rd",   32'(bus.text_rd),   32'h1);
    step();
    chk("last_font_addr", 32'(bus.font_addr), 32'({text_f(12'd3700), 4'hF}));
    step(2);
    chk("last_data", 32'(bus.pix_data), 32'(font_f(text_f(12'd3700), 4'hF)));
    reads_snap = text_reads;

    // Line 608 and beyond: blank rows, no memory traffic.
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("blank_text_rd", 32'(bus.text_rd), 32'h0);
    step();
    chk("blank_font_rd", 32'(bus.font_rd), 32'h0);
    step();
    chk("blank_valid", 32'(bus.pix_valid), 32'h1);
    chk("blank_data",  32'(bus.pix_data),  32'h00);
    for (int i = 0; i < 50; i++) begin
      line_start = 1'b1; step(); line_start = 1'b0; step(3);
    end
    chk("sat_valid", 32'(bus.pix_valid), 32'h1);
    chk("sat_data",  32'(bus.pix_data),  32'h00);
    chk("sat_no_reads", 32'(text_reads), 32'(reads_snap));

    // Reset in the middle of a fetch.
    frame_start = 1'b1; step(); frame_start = 1'b0; step(3);
    chk("pre_rst_data", 32'(bus.pix_data), 32'h18);
    bus.pix_ack = 1'b1; step(); bus.pix_ack = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid",   32'(bus.pix_valid), 32'h0);
    chk("mid_rst_data",    32'(bus.pix_data),  32'h00);
    chk("mid_rst_text_rd", 32'(bus.text_rd),   32'h0);
    chk("mid_rst_font_rd", 32'(bus.font_rd),   32'h0);

    // line_start straight out of reset: scan 1 of row 0.
    line_start = 1'b1; step(); line_start = 1'b0;
    chk("post_rst_text_addr", 32'(bus.text_addr), 32'h0);
    step();
    chk("post_rst_font_addr", 32'(bus.font_addr), 32'h411);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/text_fetch.md
Name: text_fetch

Overview:
Text-mode fetch stage that sits directly upstream of the pixel generator's 8-bit pixel register. For each 8-pixel character cell, it reads a character code from text RAM, then that code's font row from font ROM. It presents the resulting 8-bit pattern (MSB = leftmost pixel, 1 = foreground) through a valid/ack handshake. It tracks character row and scanline itself from frame_start/line_start pulses produced by the sync timing logic.

Parameters:
COLS, 100, character cells per line (800 px / 8)
ROWS, 38, character rows per frame (600 / 16, last row half shown)
FONT_H, 16, scanlines per glyph; must be a power of two
TEXT_AW, 12, text RAM address width (COLS*ROWS must fit)
FONT_AW, 12, font ROM address width; equals 8 + log2(FONT_H)

Ports:
clk  in  1  pixel clock (global buffer output)
rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse during vertical blanking, before visible line 0
line_start  in  1  one-cycle pulse at the end of each visible line's visible region, meaning "prefetch next line"
pix_ack  in  1  consumer took pix_data this cycle
pix_data  out  8  current glyph row byte
pix_valid  out  1  pix_data holds an unconsumed byte
text_addr  out  TEXT_AW  text RAM address (row_base + col)
text_rd  out  1  text RAM read enable
text_data  in  8  character code; valid the cycle after text_rd
font_addr  out  FONT_AW  font ROM address {text_data, scan}
font_rd  out  1  font ROM read enable
font_data  in  8  glyph row; valid the cycle after font_rd

Behaviour:
- One clock, clk; reset synchronous active-high on rst. Reset overrides all other inputs and aborts any fetch in progress.
- Reset values: state IDLE, pix_valid 0, pix_data 0x00, text_rd 0, font_rd 0, col 0, scan 0, row_base 0.
- Internal registers:
  - col: 0..COLS
  - scan: 0..FONT_H-1
  - row_base: advances in steps of COLS
  - blank flag: set when row_base >= COLS*ROWS
- States:
  - IDLE
  - CHAR: text_rd=1; text_addr=row_base+col
  - FONT: font_rd=1; font_addr={text_data, scan}
  - LOAD
  - HOLD
  - DONE
- Read strobes and addresses are combinational from state. Both read strobes are 0 outside CHAR/FONT, and addresses are 0 outside those states.
- Transitions:
  - CHAR -> FONT
  - FONT -> LOAD
  - LOAD: pix_data <= font_data (0x00 if blank), pix_valid <= 1, col <= col+1 -> HOLD
  - HOLD with pix_ack: pix_valid <= 0 (pix_data retained); go to CHAR if col<COLS, else DONE
- Blank rows: CHAR goes directly to LOAD with text_rd=0, and no font read is made.
- frame_start: scan <= 0, row_base <= 0, col <= 0, pix_valid <= 0 -> CHAR.
- line_start:
  - col <= 0, pix_valid <= 0 -> CHAR.
  - If scan==FONT_H-1: scan <= 0 and row_base <= row_base+COLS.
  - Otherwise scan <= scan+1.
- Latency: pix_valid rises 3 clock edges after the edge that samples frame_start, line_start or pix_ack. This is well inside the consumer's 8-cycle byte period.
- Boundary conditions:
  - frame_start and line_start in the same cycle: frame_start wins.
  - Either pulse arriving in any state, including mid-fetch: abort the fetch and restart as above. Stale memory data is discarded.
  - pix_ack while pix_valid=0: ignored.
  - pix_ack in DONE: ignored; pix_data keeps its last value.
  - line_start before any frame_start: processed normally from reset values.
  - row_base is never advanced past COLS*ROWS (saturates). Extra line_starts keep blank rows.
- Width rule: row_base+col is computed at TEXT_AW bits; no truncation, given the parameter constraint.

Decomposition:
- Shared header: COLS, ROWS, FONT_H and state encodings (3-bit, localparam), plus H/V timing constants so that frame_start/line_start decode is consistent with syncgen.
- Single module. The row_base/scan tracker is small enough to stay inline; no sub-module.

Test Plan:
- rst=1 for 2 cycles, then frame_start -> text_rd=1, text_addr=0 after one edge; font_addr={text_data,4'h0}; pix_valid=1, pix_data=font_data 3 edges after frame_start.
- Text RAM all 0x41, font row 'A'/scan 0 = 0x18; ack every 8 cycles -> 100 bytes of 0x18 on text_addr 0..99, then DONE with no further reads.
- 16 line_start pulses after frame_start -> scan wraps 15->0, next text_addr=100, font_addr={code,4'h0}.
- line_start asserted mid-fetch in FONT state -> fetch aborted, restart at text_addr=row_base+0 with the new scan; no stale byte is presented.
- frame_start and line_start in the same cycle -> scan=0, text_addr=0.
- Drive 608 lines -> rows 0..37 read normally; line_starts beyond 608 yield pix_data=0x00 with text_rd=font_rd=0; rst mid-line -> outputs return to reset values next edge.
